// File: rtl/lc4_mux_nx1_reg.sv
// Registered N:1 word mux, directed (sel) or round-robin. Latency: 1 cycle, in_ready -> out_valid.
// Backpressure: a held word blocks all in_ready until out_ready; the slot reloads in the cycle it drains.
module lc4_mux_nx1_reg #(
    parameter int WIDTH = 16,
    parameter int N     = 16,
    parameter int SEL_W = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_ch,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               err_sel
);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_ch;
    logic             r_out_valid;
    logic             r_err_sel;
    logic [SEL_W-1:0] r_ptr;

    logic             w_load_en;
    logic             w_gnt_vld;
    logic [SEL_W-1:0] w_gnt;
    logic [WIDTH-1:0] w_gnt_data;
    logic             w_sel_bad;
    int               w_idx;

    assign w_load_en = !r_out_valid || out_ready;
    assign w_sel_bad = !mode && w_load_en && (int'(sel) >= N);

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_idx     = 0;
        if (w_load_en) begin
            if (!mode) begin
                // Out-of-range sel never matches any k, so it is never granted.
                for (int k = 0; k < N; k++) begin
                    if (sel == SEL_W'(k) && in_valid[k]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt     = SEL_W'(k);
                    end
                end
            end else begin
                // Search starts just after the last winner and ends on it.
                for (int i = 1; i <= N; i++) begin
                    w_idx = int'(r_ptr) + i;
                    if (w_idx >= N) w_idx = w_idx - N;
                    if (!w_gnt_vld && in_valid[w_idx]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt     = SEL_W'(w_idx);
                    end
                end
            end
        end
    end

    always_comb begin
        w_gnt_data = '0;
        in_ready   = '0;
        for (int k = 0; k < N; k++) begin
            if (w_gnt == SEL_W'(k)) w_gnt_data = in_data[k*WIDTH +: WIDTH];
            in_ready[k] = w_gnt_vld && (w_gnt == SEL_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_err_sel   <= 1'b0;
            r_ptr       <= SEL_W'(N - 1);
        end else begin
            r_err_sel <= w_sel_bad;
            if (w_gnt_vld) begin
                r_out_data  <= w_gnt_data;
                r_out_ch    <= w_gnt;
                r_out_valid <= 1'b1;
                if (mode) r_ptr <= w_gnt;
            end else if (w_load_en) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign err_sel   = r_err_sel;

endmodule

// File: tb/tb_lc4_mux_nx1_reg.sv
// Directed bench for lc4_mux_nx1_reg: a 16-channel instance and a 10-channel instance for illegal sel.
module tb_lc4_mux_nx1_reg;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // 16-channel instance
    logic          a_mode, a_out_ready, a_out_valid, a_err_sel;
    logic [3:0]    a_sel, a_out_ch;
    logic [255:0]  a_in_data;
    logic [15:0]   a_in_valid, a_in_ready, a_out_data;

    // 10-channel instance
    logic          b_mode, b_out_ready, b_out_valid, b_err_sel;
    logic [3:0]    b_sel, b_out_ch;
    logic [159:0]  b_in_data;
    logic [9:0]    b_in_valid, b_in_ready;
    logic [15:0]   b_out_data;

    lc4_mux_nx1_reg #(.WIDTH(16), .N(16), .SEL_W(4)) u_dut16 (
        .clk(clk), .rstn(rstn), .mode(a_mode), .sel(a_sel),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .err_sel(a_err_sel)
    );

    lc4_mux_nx1_reg #(.WIDTH(16), .N(10), .SEL_W(4)) u_dut10 (
        .clk(clk), .rstn(rstn), .mode(b_mode), .sel(b_sel),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .err_sel(b_err_sel)
    );

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [15:0] a_word(int k);
        return (k == 5) ? 16'hA5A5 : (16'hC000 | 16'(k));
    endfunction

    function automatic logic [15:0] b_word(int k);
        return 16'hB000 | 16'(k);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rr_exp[9];
    logic [15:0] rr_vld[9];

    initial begin
        rstn        = 1'b0;
        a_mode      = 1'b0; a_sel = 4'd0; a_in_valid = '0; a_out_ready = 1'b1;
        b_mode      = 1'b0; b_sel = 4'd0; b_in_valid = '0; b_out_ready = 1'b1;
        for (int k = 0; k < 16; k++) a_in_data[k*16 +: 16] = a_word(k);
        for (int k = 0; k < 10; k++) b_in_data[k*16 +: 16] = b_word(k);

        // reset / idle
        tick(); tick();
        rstn = 1'b1;
        tick();
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_data",  32'(a_out_data),  32'd0);
        check("rst_out_ch",    32'(a_out_ch),    32'd0);
        check("rst_err_sel",   32'(a_err_sel),   32'd0);
        check("rst_in_ready",  32'(a_in_ready),  32'd0);
        check("rst_b_valid",   32'(b_out_valid), 32'd0);

        // directed forward of channel 5
        a_mode = 1'b0; a_sel = 4'd5; a_in_valid = 16'hFFFF; a_out_ready = 1'b1;
        #1;
        check("dir_in_ready", 32'(a_in_ready), 32'h0020);
        tick();
        check("dir_out_data",  32'(a_out_data),  32'hA5A5);
        check("dir_out_ch",    32'(a_out_ch),    32'd5);
        check("dir_out_valid", 32'(a_out_valid), 32'd1);

        // sel sweep: one word per cycle
        for (int s = 0; s < 16; s++) begin
            a_sel = 4'(s);
            #1;
            check("sweep_in_ready", 32'(a_in_ready), 32'(16'h0001 << s));
            tick();
            check("sweep_out_ch",   32'(a_out_ch),    32'(s));
            check("sweep_out_data", 32'(a_out_data),  32'(a_word(s)));
            check("sweep_valid",    32'(a_out_valid), 32'd1);
        end

        // round-robin over {2,7,15}, then 7 drops after the 7th grant
        rr_exp = '{2, 7, 15, 2, 7, 15, 2, 15, 2};
        for (int i = 0; i < 9; i++) rr_vld[i] = (i < 7) ? 16'h8084 : 16'h8004;
        a_mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            a_in_valid = rr_vld[i];
            #1;
            check("rr_in_ready", 32'(a_in_ready), 32'(16'h0001 << rr_exp[i]));
            tick();
            check("rr_out_ch",    32'(a_out_ch),    32'(rr_exp[i]));
            check("rr_out_valid", 32'(a_out_valid), 32'd1);
        end

        // backpressure
        a_mode = 1'b0; a_sel = 4'd3; a_in_valid = 16'hFFFF; a_out_ready = 1'b1;
        tick();
        check("bp_load_ch", 32'(a_out_ch), 32'd3);
        a_out_ready = 1'b0; a_sel = 4'd4;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_in_ready", 32'(a_in_ready), 32'd0);
            tick();
            check("bp_out_ch",    32'(a_out_ch),    32'd3);
            check("bp_out_data",  32'(a_out_data),  32'(a_word(3)));
            check("bp_out_valid", 32'(a_out_valid), 32'd1);
        end
        a_out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(a_in_ready), 32'h0010);
        tick();
        check("bp_next_ch",   32'(a_out_ch),   32'd4);
        check("bp_next_data", 32'(a_out_data), 32'(a_word(4)));

        // illegal select on the 10-channel instance
        b_mode = 1'b0; b_sel = 4'd4; b_in_valid = 10'h3FF; b_out_ready = 1'b1;
        tick();
        check("ill_load_ch",  32'(b_out_ch),  32'd4);
        check("ill_load_err", 32'(b_err_sel), 32'd0);
        b_out_ready = 1'b0; b_sel = 4'd12;
        tick();
        check("ill_stall_err",   32'(b_err_sel),   32'd0);
        check("ill_stall_valid", 32'(b_out_valid), 32'd1);
        b_out_ready = 1'b1;
        #1;
        check("ill_in_ready", 32'(b_in_ready), 32'd0);
        tick();
        check("ill_err1",       32'(b_err_sel),   32'd1);
        check("ill_drain",      32'(b_out_valid), 32'd0);
        check("ill_hold_ch",    32'(b_out_ch),    32'd4);
        check("ill_hold_data",  32'(b_out_data),  32'(b_word(4)));
        tick();
        check("ill_err2", 32'(b_err_sel), 32'd1);
        b_sel = 4'd4;
        #1;
        check("ill_resume_in_ready", 32'(b_in_ready), 32'h010);
        tick();
        check("ill_resume_err",   32'(b_err_sel),   32'd0);
        check("ill_resume_valid", 32'(b_out_valid), 32'd1);
        check("ill_resume_ch",    32'(b_out_ch),    32'd4);

        // reset mid-operation with ptr at 6
        a_mode = 1'b1; a_in_valid = 16'h0040; a_out_ready = 1'b1;
        tick();
        check("mid_pre_ch",    32'(a_out_ch),    32'd6);
        check("mid_pre_valid", 32'(a_out_valid), 32'd1);
        rstn = 1'b0;
        tick();
        check("mid_rst_valid", 32'(a_out_valid), 32'd0);
        check("mid_rst_data",  32'(a_out_data),  32'd0);
        check("mid_rst_ch",    32'(a_out_ch),    32'd0);
        rstn = 1'b1; a_in_valid = 16'hFFFF;
        #1;
        check("mid_first_in_ready", 32'(a_in_ready), 32'h0001);
        tick();
        check("mid_first_ch",    32'(a_out_ch),    32'd0);
        check("mid_first_valid", 32'(a_out_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
